// File: rtl/sram_axi_bridge_ot_if.sv
// AXI3 master-side bus bundle for the SRAM-like bridge.
// The bridge drives through the master modport; the crossbar/RAM side uses slave.
interface sram_axi_bridge_ot_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     arid;
  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_W-1:0]     awid;
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge_ot.sv
// Inst/data SRAM-like ports onto one AXI3 master: prioritized reads with per-port
// outstanding tracking by ARID, plus a single registered write with split AW/W handshakes.

module sram_axi_bridge_ot_rd_cnt #(
  parameter int RD_OUT = 4,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic beat,
  output logic room,
  output logic hit,
  output logic busy
);
  logic [CNT_W-1:0] cnt;

  assign room = cnt < CNT_W'(RD_OUT);
  assign busy = cnt != '0;
  // A beat with nothing outstanding is stale (e.g. issued before a reset) and is dropped.
  assign hit  = beat && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (inc && !hit)  cnt <= cnt + CNT_W'(1);
    else if (!inc && hit)  cnt <= cnt - CNT_W'(1);
  end
endmodule

module sram_axi_bridge_ot #(
  parameter int DATA_W = 32,
  parameter int RD_OUT = 4,
  parameter int ID_W   = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  sram_axi_bridge_ot_if.master   axi,

  input  logic                   inst_sram_req,
  input  logic                   inst_sram_wr,
  input  logic [1:0]             inst_sram_size,
  input  logic [31:0]            inst_sram_addr,
  input  logic [DATA_W-1:0]      inst_sram_wdata,
  output logic [DATA_W-1:0]      inst_sram_rdata,
  output logic                   inst_sram_addr_ok,
  output logic                   inst_sram_data_ok,

  input  logic                   data_sram_req,
  input  logic                   data_sram_wr,
  input  logic [1:0]             data_sram_size,
  input  logic [31:0]            data_sram_addr,
  input  logic [DATA_W-1:0]      data_sram_wdata,
  input  logic [DATA_W/8-1:0]    data_sram_wstrb,
  output logic [DATA_W-1:0]      data_sram_rdata,
  output logic                   data_sram_addr_ok,
  output logic                   data_sram_data_ok
);
  localparam int NP    = 2;   // port 0 = inst, port 1 = data; port index doubles as ARID
  localparam int CNT_W = $clog2(RD_OUT + 1);
  localparam int SW    = DATA_W / 8;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [2:0]      size;
  } ar_req_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic [2:0]      size;
    logic [DATA_W-1:0] data;
    logic [SW-1:0]   strb;
  } wr_req_t;

  logic [NP-1:0]       rd_req, rd_elig, rd_room, rd_hit, rd_busy, rd_inc, rd_beat;
  logic [NP-1:0][31:0] rd_addr;
  logic [NP-1:0][1:0]  rd_size;

  ar_req_t ar_q, ar_d;
  logic    ar_vld, ar_free;
  wr_req_t wr_q;
  logic    aw_vld, w_vld, wr_busy, wr_acc, wr_req;
  logic    unused_ok;

  assign rd_req  = {data_sram_req & ~data_sram_wr, inst_sram_req & ~inst_sram_wr};
  assign rd_addr = {data_sram_addr, inst_sram_addr};
  assign rd_size = {data_sram_size, inst_sram_size};

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign rd_beat[p] = axi.rvalid && (axi.rid == ID_W'(p));
    sram_axi_bridge_ot_rd_cnt #(.RD_OUT(RD_OUT), .CNT_W(CNT_W)) u_cnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .inc   (rd_inc[p]),
      .beat  (rd_beat[p]),
      .room  (rd_room[p]),
      .hit   (rd_hit[p]),
      .busy  (rd_busy[p])
    );
  end

  // Data reads wait out an in-flight write so the data port's responses stay in order.
  assign rd_elig[0] = rd_req[0] & rd_room[0];
  assign rd_elig[1] = rd_req[1] & rd_room[1] & ~wr_busy;
  assign ar_free    = ~ar_vld | axi.arready;
  assign rd_inc[1]  = aresetn & ar_free & rd_elig[1];
  assign rd_inc[0]  = aresetn & ar_free & rd_elig[0] & ~rd_elig[1];

  always_comb begin
    ar_d      = '0;
    ar_d.id   = rd_inc[1] ? ID_W'(1) : ID_W'(0);
    ar_d.addr = rd_inc[1] ? rd_addr[1] : rd_addr[0];
    ar_d.size = {1'b0, rd_inc[1] ? rd_size[1] : rd_size[0]};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_vld <= 1'b0;
      ar_q   <= '0;
    end else if (|rd_inc) begin
      ar_vld <= 1'b1;
      ar_q   <= ar_d;
    end else if (axi.arready) begin
      ar_vld <= 1'b0;
    end
  end

  // Writes need the data port fully drained of reads and the previous write retired.
  assign wr_req = data_sram_req & data_sram_wr;
  assign wr_acc = aresetn & wr_req & ~wr_busy & ~rd_busy[1] & ~aw_vld & ~w_vld & ~rd_inc[1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_vld  <= 1'b0;
      w_vld   <= 1'b0;
      wr_busy <= 1'b0;
      wr_q    <= '0;
    end else if (wr_acc) begin
      aw_vld  <= 1'b1;
      w_vld   <= 1'b1;
      wr_busy <= 1'b1;
      wr_q    <= '{addr: data_sram_addr, size: {1'b0, data_sram_size},
                   data: data_sram_wdata, strb: data_sram_wstrb};
    end else begin
      if (axi.awready) aw_vld  <= 1'b0;
      if (axi.wready)  w_vld   <= 1'b0;
      if (axi.bvalid)  wr_busy <= 1'b0;
    end
  end

  assign inst_sram_addr_ok = rd_inc[0];
  assign data_sram_addr_ok = rd_inc[1] | wr_acc;
  assign inst_sram_data_ok = aresetn & rd_hit[0];
  assign data_sram_data_ok = aresetn & (rd_hit[1] | (axi.bvalid & wr_busy));
  assign inst_sram_rdata   = axi.rdata;
  assign data_sram_rdata   = axi.rdata;

  assign axi.arid    = ar_q.id;
  assign axi.araddr  = ar_q.addr;
  assign axi.arsize  = ar_q.size;
  assign axi.arvalid = ar_vld;
  assign axi.arlen   = 4'd0;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.rready  = aresetn;

  assign axi.awid    = ID_W'(1);
  assign axi.awaddr  = wr_q.addr;
  assign axi.awsize  = wr_q.size;
  assign axi.awvalid = aw_vld;
  assign axi.awlen   = 4'd0;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;

  assign axi.wid     = ID_W'(1);
  assign axi.wdata   = wr_q.data;
  assign axi.wstrb   = wr_q.strb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_vld;
  assign axi.bready  = aresetn;

  assign unused_ok = ^{inst_sram_wdata, axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_sram_axi_bridge_ot.sv
// Bench for sram_axi_bridge_ot: directed scenarios plus a randomized run scored
// against a queue-based model of per-port request/response ordering.
module tb_sram_axi_bridge_ot;
  localparam int DATA_W = 32;
  localparam int RD_OUT = 4;
  localparam int ID_W   = 4;

  logic aclk, aresetn;
  logic inst_sram_req, inst_sram_wr;
  logic [1:0] inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic inst_sram_addr_ok, inst_sram_data_ok;
  logic data_sram_req, data_sram_wr;
  logic [1:0] data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0] data_sram_wstrb;
  logic data_sram_addr_ok, data_sram_data_ok;

  int checks = 0;
  int failures = 0;

  sram_axi_bridge_ot_if #(.DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  sram_axi_bridge_ot #(.DATA_W(DATA_W), .RD_OUT(RD_OUT), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .axi(axi),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_rdata(data_sram_rdata), .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {bit wr; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
  typedef struct {logic [ID_W-1:0] id; logic [31:0] addr; logic [2:0] size;} ar_t;

  function automatic logic [31:0] rfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic step;
    @(posedge aclk); #1;
  endtask

  task automatic idle;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2; data_sram_addr = 0; data_sram_wdata = 0;
    data_sram_wstrb = 0;
    axi.arready = 1; axi.awready = 0; axi.wready = 0;
    axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1;
    axi.bvalid = 0; axi.bid = 1; axi.bresp = 0;
  endtask

  task automatic test_reset;
    aresetn = 0; idle();
    inst_sram_req = 1; data_sram_req = 1; data_sram_wr = 1; axi.rvalid = 1; axi.bvalid = 1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if ({axi.arvalid, axi.awvalid, axi.wvalid} !== 3'b000) begin failures++;
      $display("FAIL rst_valids got=%b exp=000", {axi.arvalid, axi.awvalid, axi.wvalid}); end
    checks++; if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0) begin
      failures++; $display("FAIL rst_oks got=%b exp=0000",
        {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}); end
    step(); idle(); aresetn = 1;
    inst_sram_req = 1; inst_sram_wr = 1;  // unsupported inst write
    @(negedge aclk);
    checks++; if ({axi.rready, axi.bready} !== 2'b11) begin failures++;
      $display("FAIL ready_high got=%b exp=11", {axi.rready, axi.bready}); end
    checks++; if ({axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot} !== {4'd0, 2'b01, 2'b00, 4'd0, 3'd0})
      begin failures++; $display("FAIL ar_consts got=%h", {axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot}); end
    checks++; if ({axi.awid, axi.awlen, axi.awburst, axi.awlock, axi.awcache, axi.awprot, axi.wid, axi.wlast} !==
                  {4'd1, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 1'b1}) begin failures++;
      $display("FAIL aw_consts got=%h", {axi.awid, axi.awlen, axi.awburst, axi.awlock, axi.awcache, axi.awprot, axi.wid, axi.wlast}); end
    checks++; if (inst_sram_addr_ok !== 1'b0) begin failures++;
      $display("FAIL inst_wr_no_addr_ok got=%b exp=0", inst_sram_addr_ok); end
    step(); @(negedge aclk);
    checks++; if (axi.arvalid !== 1'b0) begin failures++; $display("FAIL inst_wr_no_ar got=%b exp=0", axi.arvalid); end
    step(); idle();
  endtask

  task automatic test_inst_read;
    inst_sram_req = 1; inst_sram_size = 2; inst_sram_addr = 32'h1FC0_0000;
    @(negedge aclk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL ir_addr_ok got=%b exp=1", inst_sram_addr_ok); end
    step(); inst_sram_req = 0;
    @(negedge aclk);
    checks++; if ({axi.arvalid, axi.arid, axi.arsize, axi.araddr} !== {1'b1, 4'd0, 3'b010, 32'h1FC0_0000}) begin failures++;
      $display("FAIL ir_ar got=%b/%h/%b/%h exp=1/0/010/1fc00000", axi.arvalid, axi.arid, axi.arsize, axi.araddr); end
    step(); @(negedge aclk);
    checks++; if ({axi.arvalid, inst_sram_data_ok} !== 2'b00) begin failures++;
      $display("FAIL ir_quiet got=%b exp=00", {axi.arvalid, inst_sram_data_ok}); end
    step(); axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hDEAD_BEEF;
    @(negedge aclk);
    checks++; if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin failures++;
      $display("FAIL ir_data got=%b%b/%h exp=10/deadbeef", inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata); end
    step(); idle();
  endtask

  task automatic test_arb;
    inst_sram_req = 1; inst_sram_addr = 32'h0000_1000; data_sram_req = 1; data_sram_addr = 32'h0000_2000;
    @(negedge aclk);
    checks++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) begin failures++;
      $display("FAIL arb_first got=%b exp=10", {data_sram_addr_ok, inst_sram_addr_ok}); end
    step(); data_sram_req = 0; axi.arready = 0;
    @(negedge aclk);
    checks++; if ({axi.arvalid, axi.arid, axi.araddr, inst_sram_addr_ok} !== {1'b1, 4'd1, 32'h2000, 1'b0}) begin failures++;
      $display("FAIL arb_ar_data got=%b/%h/%h/%b", axi.arvalid, axi.arid, axi.araddr, inst_sram_addr_ok); end
    step(); axi.arready = 1;
    @(negedge aclk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL arb_inst_ok got=%b exp=1", inst_sram_addr_ok); end
    step(); inst_sram_req = 0;
    @(negedge aclk);
    checks++; if ({axi.arvalid, axi.arid, axi.araddr} !== {1'b1, 4'd0, 32'h1000}) begin failures++;
      $display("FAIL arb_ar_inst got=%b/%h/%h", axi.arvalid, axi.arid, axi.araddr); end
    step(); axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'hAAAA_0001;
    @(negedge aclk);
    checks++; if ({data_sram_data_ok, inst_sram_data_ok, data_sram_rdata} !== {2'b10, 32'hAAAA_0001}) begin failures++;
      $display("FAIL arb_r1 got=%b%b/%h", data_sram_data_ok, inst_sram_data_ok, data_sram_rdata); end
    step(); axi.rid = 0; axi.rdata = 32'hBBBB_0002;
    @(negedge aclk);
    checks++; if ({data_sram_data_ok, inst_sram_data_ok, inst_sram_rdata} !== {2'b01, 32'hBBBB_0002}) begin failures++;
      $display("FAIL arb_r0 got=%b%b/%h", data_sram_data_ok, inst_sram_data_ok, inst_sram_rdata); end
    step(); idle();
  endtask

  task automatic test_outstanding;
    int oks = 0;
    inst_sram_req = 1;
    for (int c = 0; c < 6; c++) begin
      inst_sram_addr = 32'h100 + 32'(c * 4);
      @(negedge aclk);
      if (inst_sram_addr_ok === 1'b1) begin oks++; inst_sram_addr = inst_sram_addr + 32'h40; end
      step();
    end
    checks++; if (oks !== RD_OUT) begin failures++; $display("FAIL ot_stall got=%0d exp=%0d", oks, RD_OUT); end
    axi.rvalid = 1; axi.rid = 0;
    @(negedge aclk);
    checks++; if ({inst_sram_data_ok, inst_sram_addr_ok} !== 2'b10) begin failures++;
      $display("FAIL ot_beat got=%b exp=10", {inst_sram_data_ok, inst_sram_addr_ok}); end
    step(); axi.rvalid = 0;
    @(negedge aclk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL ot_fifth got=%b exp=1", inst_sram_addr_ok); end
    step(); inst_sram_req = 0; axi.rvalid = 1;
    oks = 0;
    for (int c = 0; c < RD_OUT + 1; c++) begin
      @(negedge aclk);
      if (inst_sram_data_ok === 1'b1) oks++;
      step();
    end
    checks++; if (oks !== RD_OUT) begin failures++; $display("FAIL ot_drain got=%0d exp=%0d", oks, RD_OUT); end
    idle();
  endtask

  task automatic test_write;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h8000_1000; data_sram_wdata = 32'h1234_5678;
    data_sram_wstrb = 4'b0011; data_sram_size = 2;
    @(negedge aclk);
    checks++; if (data_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL wr_addr_ok got=%b exp=1", data_sram_addr_ok); end
    step(); data_sram_req = 0; data_sram_wr = 0; axi.awready = 1;
    @(negedge aclk);
    checks++; if ({axi.awvalid, axi.wvalid, axi.awaddr, axi.awsize, axi.wdata, axi.wstrb} !==
                  {2'b11, 32'h8000_1000, 3'b010, 32'h1234_5678, 4'b0011}) begin failures++;
      $display("FAIL wr_payload got=%b%b/%h/%b/%h/%b", axi.awvalid, axi.wvalid, axi.awaddr, axi.awsize, axi.wdata, axi.wstrb); end
    step(); axi.awready = 0; data_sram_req = 1; data_sram_addr = 32'h8000_2000;
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) axi.wready = 1;
      @(negedge aclk);
      checks++; if ({axi.awvalid, axi.wvalid, data_sram_addr_ok} !== 3'b010) begin failures++;
        $display("FAIL wr_hold_c%0d got=%b exp=010", c, {axi.awvalid, axi.wvalid, data_sram_addr_ok}); end
      step();
    end
    axi.wready = 0; axi.bvalid = 1;
    @(negedge aclk);
    checks++; if ({axi.wvalid, data_sram_data_ok, data_sram_addr_ok} !== 3'b010) begin failures++;
      $display("FAIL wr_bresp got=%b exp=010", {axi.wvalid, data_sram_data_ok, data_sram_addr_ok}); end
    step(); axi.bvalid = 0;
    @(negedge aclk);
    checks++; if (data_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL wr_rd_after got=%b exp=1", data_sram_addr_ok); end
    step(); data_sram_req = 0;
    @(negedge aclk);
    checks++; if ({axi.arvalid, axi.arid, axi.araddr} !== {1'b1, 4'd1, 32'h8000_2000}) begin failures++;
      $display("FAIL wr_rd_ar got=%b/%h/%h", axi.arvalid, axi.arid, axi.araddr); end
    step(); axi.rvalid = 1; axi.rid = 1;
    @(negedge aclk);
    checks++; if (data_sram_data_ok !== 1'b1) begin failures++; $display("FAIL wr_rd_data got=%b exp=1", data_sram_data_ok); end
    step(); idle();
  endtask

  task automatic test_write_wait;
    data_sram_req = 1; data_sram_addr = 32'h300;
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      checks++; if (data_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL ww_rd%0d got=%b exp=1", c, data_sram_addr_ok); end
      step(); data_sram_addr = 32'h304;
    end
    data_sram_wr = 1; data_sram_addr = 32'h400; data_sram_wdata = 32'hCAFE_F00D; data_sram_wstrb = 4'hF;
    for (int c = 0; c < 4; c++) begin
      axi.rvalid = (c >= 2); axi.rid = 1;
      @(negedge aclk);
      checks++; if ({data_sram_addr_ok, data_sram_data_ok} !== {1'b0, c >= 2}) begin failures++;
        $display("FAIL ww_wait%0d got=%b exp=0%b", c, {data_sram_addr_ok, data_sram_data_ok}, c >= 2); end
      step();
    end
    axi.rvalid = 0;
    @(negedge aclk);
    checks++; if (data_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL ww_accept got=%b exp=1", data_sram_addr_ok); end
    step(); data_sram_req = 0; data_sram_wr = 0; axi.awready = 1; axi.wready = 1;
    @(negedge aclk);
    checks++; if ({axi.awvalid, axi.wvalid, axi.awaddr} !== {2'b11, 32'h400}) begin failures++;
      $display("FAIL ww_aw got=%b%b/%h", axi.awvalid, axi.wvalid, axi.awaddr); end
    step(); axi.bvalid = 1;
    @(negedge aclk);
    checks++; if ({data_sram_data_ok, axi.awvalid, axi.wvalid} !== 3'b100) begin failures++;
      $display("FAIL ww_b got=%b exp=100", {data_sram_data_ok, axi.awvalid, axi.wvalid}); end
    step(); idle();
  endtask

  task automatic test_reset_mid;
    inst_sram_req = 1;
    for (int c = 0; c < 3; c++) begin inst_sram_addr = 32'h500 + 32'(c * 4); step(); end
    inst_sram_req = 0; axi.arready = 0;
    @(negedge aclk);
    checks++; if (axi.arvalid !== 1'b1) begin failures++; $display("FAIL rm_pre got=%b exp=1", axi.arvalid); end
    #2 aresetn = 0; inst_sram_req = 1; #1;
    checks++; if ({axi.arvalid, inst_sram_addr_ok} !== 2'b00) begin failures++;
      $display("FAIL rm_async got=%b exp=00", {axi.arvalid, inst_sram_addr_ok}); end
    step(); idle(); aresetn = 1; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h5555_AAAA;
    @(negedge aclk);
    checks++; if ({inst_sram_data_ok, axi.arvalid} !== 2'b00) begin failures++;
      $display("FAIL rm_stale got=%b exp=00", {inst_sram_data_ok, axi.arvalid}); end
    step(); idle();
  endtask

  task automatic test_random(input int ncyc);
    logic [31:0] q_i[$]; req_t q_d[$]; ar_t q_ar[$]; logic [31:0] pend_i[$]; logic [31:0] pend_d[$];
    bit i_act = 0, d_act = 0, aw_done = 0, w_done = 0, b_now, r_sent, has_wr;
    logic [31:0] i_addr = 0, r_addr = 0, exp_a; logic [1:0] i_size = 0; logic [ID_W-1:0] r_id = 0;
    req_t cur = '{default: 0}, e; ar_t a; int nqi, nqd, done_cnt = 0, bad = 0;
    for (int c = 0; c < ncyc + 400; c++) begin
      if (c < ncyc && !i_act && $urandom_range(2) == 0) begin
        i_act = 1; i_addr = $urandom & 32'hFFFF_FFFC; i_size = 2'($urandom_range(2)); end
      if (c < ncyc && !d_act && $urandom_range(2) == 0) begin
        d_act = 1; cur.wr = ($urandom_range(3) == 0); cur.addr = $urandom & 32'hFFFF_FFFC;
        cur.size = 2'($urandom_range(2)); cur.wdata = $urandom; cur.wstrb = 4'($urandom); end
      inst_sram_req = i_act; inst_sram_addr = i_addr; inst_sram_size = i_size;
      data_sram_req = d_act; data_sram_wr = cur.wr; data_sram_addr = cur.addr; data_sram_size = cur.size;
      data_sram_wdata = cur.wdata; data_sram_wstrb = cur.wstrb;
      axi.arready = ($urandom_range(3) != 0); axi.awready = 1'($urandom); axi.wready = 1'($urandom);
      b_now = aw_done && w_done && ($urandom_range(1) == 1); axi.bvalid = b_now;
      r_sent = 0;
      if ($urandom_range(1) == 1) begin
        if (pend_d.size() > 0 && (pend_i.size() == 0 || $urandom_range(1) == 1)) begin
          r_sent = 1; r_id = 1; r_addr = pend_d.pop_front(); end
        else if (pend_i.size() > 0) begin r_sent = 1; r_id = 0; r_addr = pend_i.pop_front(); end
      end
      axi.rvalid = r_sent; axi.rid = r_id; axi.rdata = r_sent ? rfn(r_addr) : $urandom;
      @(negedge aclk);
      nqi = q_i.size(); nqd = q_d.size(); has_wr = (nqd > 0) && q_d[0].wr;
      checks++; if (inst_sram_data_ok !== (r_sent && r_id == 0)) begin failures++;
        $display("FAIL rnd_ido c=%0d got=%b exp=%b", c, inst_sram_data_ok, r_sent && r_id == 0); end
      checks++; if (data_sram_data_ok !== ((r_sent && r_id == 1) || b_now)) begin failures++;
        $display("FAIL rnd_ddo c=%0d got=%b exp=%b", c, data_sram_data_ok, (r_sent && r_id == 1) || b_now); end
      if (axi.arvalid && axi.arready) begin
        checks++;
        if (q_ar.size() == 0) begin failures++; $display("FAIL rnd_ar_spurious c=%0d", c); end
        else begin
          a = q_ar.pop_front();
          if ({axi.arid, axi.araddr, axi.arsize} !== {a.id, a.addr, a.size}) begin failures++;
            $display("FAIL rnd_ar c=%0d got=%h/%h/%b exp=%h/%h/%b", c, axi.arid, axi.araddr, axi.arsize, a.id, a.addr, a.size); end
          if (a.id == 0) pend_i.push_back(a.addr); else pend_d.push_back(a.addr);
        end
      end
      if (axi.awvalid && axi.awready) begin
        checks++;
        if (!has_wr || aw_done || {axi.awaddr, axi.awsize} !== {q_d[0].addr, 1'b0, q_d[0].size}) begin failures++;
          $display("FAIL rnd_aw c=%0d got=%h/%b", c, axi.awaddr, axi.awsize); end
        aw_done = 1;
      end
      if (axi.wvalid && axi.wready) begin
        checks++;
        if (!has_wr || w_done || {axi.wdata, axi.wstrb} !== {q_d[0].wdata, q_d[0].wstrb}) begin failures++;
          $display("FAIL rnd_w c=%0d got=%h/%b", c, axi.wdata, axi.wstrb); end
        w_done = 1;
      end
      if (b_now) begin aw_done = 0; w_done = 0; end
      checks++; if (inst_sram_addr_ok && data_sram_addr_ok && !cur.wr) begin failures++;
        $display("FAIL rnd_two_rd c=%0d got=11 exp=one", c); end
      if (inst_sram_addr_ok) begin
        checks++; if (!i_act || nqi >= RD_OUT) begin failures++;
          $display("FAIL rnd_iaok c=%0d act=%b outstanding=%0d", c, i_act, nqi); end
      end
      if (data_sram_addr_ok) begin
        checks++; if (!d_act || (cur.wr ? nqd != 0 : (has_wr || nqd >= RD_OUT))) begin failures++;
          $display("FAIL rnd_daok c=%0d act=%b wr=%b outstanding=%0d", c, d_act, cur.wr, nqd); end
      end
      if (inst_sram_data_ok) begin
        done_cnt++; checks++;
        exp_a = (q_i.size() > 0) ? q_i.pop_front() : 32'hX;
        if (inst_sram_rdata !== rfn(exp_a)) begin failures++;
          $display("FAIL rnd_irdata c=%0d got=%h exp=%h", c, inst_sram_rdata, rfn(exp_a)); end
      end
      if (data_sram_data_ok) begin
        done_cnt++; checks++;
        if (q_d.size() == 0) begin failures++; $display("FAIL rnd_d_spurious c=%0d", c); end
        else begin
          e = q_d.pop_front();
          if (e.wr ? !b_now : (!r_sent || data_sram_rdata !== rfn(e.addr))) begin failures++;
            $display("FAIL rnd_dresp c=%0d wr=%b got=%h exp=%h", c, e.wr, data_sram_rdata, rfn(e.addr)); end
        end
      end
      if (data_sram_addr_ok && d_act) begin
        q_d.push_back(cur);
        if (!cur.wr) q_ar.push_back('{id: 1, addr: cur.addr, size: {1'b0, cur.size}});
        d_act = 0;
      end
      if (inst_sram_addr_ok && i_act) begin
        q_i.push_back(i_addr); q_ar.push_back('{id: 0, addr: i_addr, size: {1'b0, i_size}}); i_act = 0;
      end
      step();
    end
    bad = q_i.size() + q_d.size() + q_ar.size() + pend_i.size() + pend_d.size() + int'(i_act) + int'(d_act);
    checks++; if (bad != 0) begin failures++; $display("FAIL rnd_drain got=%0d exp=0", bad); end
    checks++; if (done_cnt < 100) begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", done_cnt); end
    idle();
  endtask

  initial begin
    aresetn = 0;
    idle();
    test_reset();
    test_inst_read();
    test_arb();
    test_outstanding();
    test_write();
    test_write_wait();
    test_reset_mid();
    test_random(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge_ot.md
Name: sram_axi_bridge_ot

Overview:
- Successor to the single-transfer SRAM-like-to-AXI3 bridge: connects the CPU's inst and data SRAM-like ports to one AXI3 master interface.
- Adds fixed-priority read arbitration, up to RD_OUT outstanding reads per port (tracked by ARID), a registered AW/W path with independent handshakes, and per-port response ordering.
- Sits between the mycpu core and the AXI crossbar/RAM.

Parameters:
- DATA_W, 32, data bus width (rdata/wdata/sram data); wstrb width is DATA_W/8.
- RD_OUT, 4, maximum outstanding reads per port, legal 1..15; counter width clog2(RD_OUT+1).
- ID_W, 4, AXI id width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- arid/araddr/arsize  out  ID_W/32/3  read request payload.
- arvalid  out  1 / arready  in  1  read request handshake.
- rid  in  ID_W / rdata  in  DATA_W / rresp  in  2 / rlast  in  1 / rvalid  in  1  read response.
- rready  out  1  read response ready.
- awaddr/awsize  out  32/3  write address payload.
- awvalid  out  1 / awready  in  1  write address handshake.
- wdata/wstrb  out  DATA_W/DATA_W/8  write data.
- wvalid  out  1 / wready  in  1  write data handshake.
- bid  in  ID_W / bresp  in  2 / bvalid  in  1  write response.
- bready  out  1  write response ready.
- Constant outputs: arlen, arburst, arlock, arcache, arprot, awid, awlen, awburst, awlock, awcache, awprot, wid, wlast (values in Behaviour).
- inst_sram_req/wr  in  1, inst_sram_size  in  2, inst_sram_addr  in  32, inst_sram_wdata  in  DATA_W.
- inst_sram_rdata  out  DATA_W, inst_sram_addr_ok/data_ok  out  1.
- data_sram_req/wr  in  1, data_sram_size  in  2, data_sram_addr  in  32, data_sram_wdata  in  DATA_W, data_sram_wstrb  in  DATA_W/8.
- data_sram_rdata  out  DATA_W, data_sram_addr_ok/data_ok  out  1.

Behaviour:
- Constants: arlen=0, arburst=01, arlock=00, arcache=0, arprot=0, awid=1, awlen=0, awburst=01, awlock=00, awcache=0, awprot=0, wid=1, wlast=1.
- rready=1 and bready=1 whenever aresetn high. rresp, bresp, rlast and bid are ignored.
- Reset (async, aresetn low): arvalid/awvalid/wvalid=0, both read counters=0, wr_busy=0. All addr_ok/data_ok are forced to 0 while aresetn is low.
- AR register: when free (arvalid=0, or arvalid&arready this cycle), it loads one granted read. Payload: araddr=addr, arsize={0,size}, arid=0 for inst, 1 for data. arvalid asserts the next cycle and holds with stable payload until arready.
- Read grant: data read (data_sram_req&!data_sram_wr) wins over inst read in the same cycle.
- A port's read is eligible only if its count<RD_OUT. A data read additionally requires wr_busy=0.
- addr_ok is combinational and pulses in the acceptance cycle only. At most one read addr_ok per cycle.
- Count per port: +1 on addr_ok, -1 on R beat with matching rid. Simultaneous +1/-1 leaves the count unchanged.
- R routing: rid=0 drives inst_sram_data_ok=1 and inst_sram_rdata=rdata in the rvalid cycle. rid=1 drives the data port likewise. Any other rid, or a beat for a port whose count is 0, is dropped with no data_ok.
- Writes: data_sram_req&data_sram_wr is accepted (data_sram_addr_ok=1) only if wr_busy=0, data read count=0, and the data port is not granted a read that cycle.
- On write accept: wr_busy=1; awaddr, awsize, wdata and wstrb are registered; awvalid=wvalid=1 next cycle. awvalid and wvalid each drop independently after their own handshake.
- bvalid: data_sram_data_ok=1 and wr_busy=0 the same cycle. A new write may be accepted from the following cycle.
- Data-port ordering: reads and writes never overlap, so data_ok order equals request order. A read beat (rid=1) and bvalid in the same cycle cannot occur legally.
- inst_sram_wr=1 is unsupported: never granted, no addr_ok.
- Reset mid-operation clears counters and valids. Stale responses after reset are dropped by the count=0 rule.

Test Plan:
- Inst read 0x1FC00000, size 2, arready=1, rdata=0xDEADBEEF at +3 cycles -> addr_ok cycle 0; arvalid cycle 1 with arid=0, arsize=010; inst data_ok with rdata 0xDEADBEEF on the rvalid cycle.
- Inst and data read requested the same cycle -> data addr_ok first with arid=1; inst addr_ok once AR frees; responses returned rid=1 then rid=0 route correctly.
- Inst issues 5 reads back-to-back, no rvalid, RD_OUT=4 -> 4 addr_ok then stall; one rid=0 beat -> 5th addr_ok the next cycle.
- Data write 0x80001000, wdata 0x12345678, wstrb 0011; awready at +1, wready at +4 -> awvalid drops after its handshake, wvalid holds until +4; a data read held until bvalid, addr_ok the cycle after bvalid.
- Write requested while 2 data reads are outstanding -> no addr_ok until both rid=1 beats arrive, then accepted.
- aresetn dropped with 3 reads outstanding, then an rid=0 beat -> valids 0 immediately; beat dropped with no inst data_ok.
